pe_dot_accum: RTL and testbench

- Consumes the per-(feature, filter) dot-product results produced by the PE dot-product stage.
- Accumulates them over a burst of consecutive dot results, i.e. the filter's channel blocks, into wider signed sums.
- Presents each completed sum set through a one-deep valid/ready output register to the PE output/drain stage.
- One instance per PE; all NUM_FEATURES*NUM_FILTERS lanes share control.

---
 rtl/pe_dot_accum_if.sv | 34 +++
 rtl/pe_dot_accum.sv | 87 ++++++++
 tb/tb_pe_dot_accum.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pe_dot_accum_if.sv
// pe_dot_accum_if: dot-result input and sum-set output bundle for pe_dot_accum.
// o_sat is present only when PE_DOT_ACCUM_SAT_EN is defined.
interface pe_dot_accum_if #(
  parameter int NUM_FEATURES     = 2,
  parameter int NUM_FILTERS      = 2,
  parameter int DOT_OUTPUT_WIDTH = 12,
  parameter int ACCUM_WIDTH      = 24,
  parameter int MAX_BURST        = 256
);
  localparam int LANES = NUM_FEATURES * NUM_FILTERS;
  localparam int CW    = $clog2(MAX_BURST + 1);
  logic                              i_valid;
  logic                              i_first;
  logic                              i_last;
  logic [LANES*DOT_OUTPUT_WIDTH-1:0] i_dot_result;
  logic                              i_ready;
  logic                              o_valid;
  logic [LANES*ACCUM_WIDTH-1:0]      o_result;
  logic [CW-1:0]                     o_beats;
  logic                              o_overflow;
  logic                              o_proto_err;
`ifdef PE_DOT_ACCUM_SAT_EN
  logic                              o_sat;
  modport master (output i_valid, i_first, i_last, i_dot_result, i_ready,
                  input  o_valid, o_result, o_beats, o_overflow, o_proto_err, o_sat);
  modport slave  (input  i_valid, i_first, i_last, i_dot_result, i_ready,
                  output o_valid, o_result, o_beats, o_overflow, o_proto_err, o_sat);
`else
  modport master (output i_valid, i_first, i_last, i_dot_result, i_ready,
                  input  o_valid, o_result, o_beats, o_overflow, o_proto_err);
  modport slave  (input  i_valid, i_first, i_last, i_dot_result, i_ready,
                  output o_valid, o_result, o_beats, o_overflow, o_proto_err);
`endif
endinterface

// File: rtl/pe_dot_accum.sv
// pe_dot_accum: per-lane burst accumulation of dot results into a one-deep valid/ready output register.
// Define PE_DOT_ACCUM_SAT_EN for saturating adds and the sticky o_sat flag; otherwise sums wrap.
module pe_dot_accum #(
  parameter int NUM_FEATURES     = 2,
  parameter int NUM_FILTERS      = 2,
  parameter int DOT_OUTPUT_WIDTH = 12,
  parameter int ACCUM_WIDTH      = 24,
  parameter int MAX_BURST        = 256
) (
  input logic          clock,
  input logic          resetn,
  pe_dot_accum_if.slave bus
);
  localparam int L  = NUM_FEATURES * NUM_FILTERS;
  localparam int DW = DOT_OUTPUT_WIDTH;
  localparam int AW = ACCUM_WIDTH;
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, ACCUM} state_t;
  state_t state, state_nx;
  logic [AW-1:0] acc [L];
  logic [AW-1:0] sum [L];
  logic [CW-1:0] cnt, cnt_nx;
  logic start, cont, done, load, perr_set;
`ifdef PE_DOT_ACCUM_SAT_EN
  logic [AW:0]  raw [L];
  logic [L-1:0] sat_hit;
`endif
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end
  // A first beat restarts the burst from either state; it is only an error mid-burst.
  always_comb begin
    start    = bus.i_valid & bus.i_first;
    cont     = bus.i_valid & !bus.i_first & (state == ACCUM);
    cnt_nx   = start ? CW'(1) : cnt + CW'(1);
    done     = (start | cont) & (bus.i_last | (cnt_nx == CW'(MAX_BURST)));
    load     = done & (!bus.o_valid | bus.i_ready);
    perr_set = (bus.i_valid & !bus.i_first & (state == IDLE)) | (start & (state == ACCUM)) | (done & !bus.i_last);
    state_nx = (start | cont) ? (done ? IDLE : ACCUM) : state;
  end
  always_comb begin
`ifdef PE_DOT_ACCUM_SAT_EN
    sat_hit = '0;
`endif
    for (int l = 0; l < L; l++) begin
`ifdef PE_DOT_ACCUM_SAT_EN
      raw[l]     = (start ? '0 : {acc[l][AW-1], acc[l]}) + (AW+1)'($signed(bus.i_dot_result[l*DW +: DW]));
      sat_hit[l] = raw[l][AW] ^ raw[l][AW-1];
      sum[l]     = sat_hit[l] ? {raw[l][AW], {(AW-1){!raw[l][AW]}}} : raw[l][AW-1:0];
`else
      sum[l]     = (start ? '0 : acc[l]) + AW'($signed(bus.i_dot_result[l*DW +: DW]));
`endif
    end
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int l = 0; l < L; l++) acc[l] <= '0;
      cnt             <= '0;
      bus.o_valid     <= 1'b0;
      bus.o_result    <= '0;
      bus.o_beats     <= '0;
      bus.o_overflow  <= 1'b0;
      bus.o_proto_err <= 1'b0;
`ifdef PE_DOT_ACCUM_SAT_EN
      bus.o_sat       <= 1'b0;
`endif
    end else begin
      if (start | cont) begin
        for (int l = 0; l < L; l++) acc[l] <= sum[l];
        cnt <= cnt_nx;
      end
      if (load) begin
        bus.o_valid <= 1'b1;
        bus.o_beats <= cnt_nx;
        for (int l = 0; l < L; l++) bus.o_result[l*AW +: AW] <= sum[l];
      end else if (bus.i_ready) begin
        bus.o_valid <= 1'b0;
      end
      bus.o_overflow  <= bus.o_overflow | (done & !load);
      bus.o_proto_err <= bus.o_proto_err | perr_set;
`ifdef PE_DOT_ACCUM_SAT_EN
      bus.o_sat       <= bus.o_sat | ((start | cont) & (|sat_hit));
`endif
    end
  end
endmodule

// File: tb/tb_pe_dot_accum.sv
// tb_pe_dot_accum: directed plus randomized bursts against an integer-sum reference model.
// Uses ACCUM_WIDTH=13 and MAX_BURST=4 so wrap/saturation and the burst limit are reachable.
module tb_pe_dot_accum;
  localparam int NF = 2, NK = 2, DW = 12, AW = 13, MB = 4;
  localparam int L = NF * NK;
  localparam int MAXV = 2**(AW-1) - 1;
  logic clock = 1'b0;
  logic resetn;
  pe_dot_accum_if #(.NUM_FEATURES(NF), .NUM_FILTERS(NK), .DOT_OUTPUT_WIDTH(DW),
                    .ACCUM_WIDTH(AW), .MAX_BURST(MB)) bus ();
  pe_dot_accum #(.NUM_FEATURES(NF), .NUM_FILTERS(NK), .DOT_OUTPUT_WIDTH(DW),
                 .ACCUM_WIDTH(AW), .MAX_BURST(MB)) dut (.clock(clock), .resetn(resetn), .bus(bus));
  always #5 clock = ~clock;
  int vectors = 0, misses = 0;
  bit in_burst = 0, mdone = 0;
  int n = 0;
  int msum [L] = '{default: 0};
  bit exp_valid = 0, exp_ovf = 0, exp_perr = 0, exp_sat = 0;
  int exp_res [L] = '{default: 0};
  int exp_beats = 0;
  task automatic chk(string nm, int got, int exp);
    vectors++;
    if (got !== exp) begin
      misses++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask
  function automatic int lane_in(int l);
    return int'($signed(bus.i_dot_result[l*DW +: DW]));
  endfunction
  function automatic int lane_out(int l);
    return int'($signed(bus.o_result[l*AW +: AW]));
  endfunction
  function automatic int wrapf(int x);
    logic [AW-1:0] t;
    t = x[AW-1:0];
    return int'($signed(t));
  endfunction
  function automatic int addf(int a, int d);
    int s = a + d;
`ifdef PE_DOT_ACCUM_SAT_EN
    if (s > MAXV) begin s = MAXV; exp_sat = 1; end
    else if (s < -MAXV - 1) begin s = -MAXV - 1; exp_sat = 1; end
`endif
    return s;
  endfunction
  // Reference: exact integer sums per burst, wrapped only when presented.
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      in_burst = 0; n = 0; exp_valid = 0; exp_beats = 0;
      exp_ovf = 0; exp_perr = 0; exp_sat = 0;
      for (int l = 0; l < L; l++) begin msum[l] = 0; exp_res[l] = 0; end
    end else begin
      mdone = 0;
      if (bus.i_valid) begin
        if (bus.i_first) begin
          if (in_burst) exp_perr = 1;
          in_burst = 1; n = 0;
          for (int l = 0; l < L; l++) msum[l] = 0;
        end
        if (!in_burst) exp_perr = 1;
        else begin
          n++;
          for (int l = 0; l < L; l++) msum[l] = addf(msum[l], lane_in(l));
          if (bus.i_last || n == MB) begin
            mdone = 1; in_burst = 0;
            if (!bus.i_last) exp_perr = 1;
          end
        end
      end
      if (mdone && (!exp_valid || bus.i_ready)) begin
        exp_valid = 1; exp_beats = n;
        for (int l = 0; l < L; l++) exp_res[l] = wrapf(msum[l]);
      end else begin
        if (mdone) exp_ovf = 1;
        if (bus.i_ready) exp_valid = 0;
      end
    end
  end
  always @(negedge clock) begin
    chk("o_valid", int'(bus.o_valid), int'(exp_valid));
    chk("o_beats", int'(bus.o_beats), exp_beats);
    chk("o_overflow", int'(bus.o_overflow), int'(exp_ovf));
    chk("o_proto_err", int'(bus.o_proto_err), int'(exp_perr));
`ifdef PE_DOT_ACCUM_SAT_EN
    chk("o_sat", int'(bus.o_sat), int'(exp_sat));
`endif
    for (int l = 0; l < L; l++) chk($sformatf("o_result lane%0d", l), lane_out(l), exp_res[l]);
  end
  task automatic drive(bit v, bit f, bit la, int a, int b, int c, int d);
    bus.i_valid = v; bus.i_first = f; bus.i_last = la;
    bus.i_dot_result = {DW'(d), DW'(c), DW'(b), DW'(a)};
    @(posedge clock); #1;
  endtask
  task automatic drive1(bit v, bit f, bit la, int x);
    drive(v, f, la, x, x, x, x);
  endtask
  task automatic idle(int k);
    repeat (k) drive1(0, 0, 0, 0);
  endtask
  task automatic do_reset(string nm);
    bus.i_valid = 0;
    resetn = 0; #2;
    chk({nm, " rst valid"}, int'(bus.o_valid), 0);
    chk({nm, " rst lane0"}, lane_out(0), 0);
    chk({nm, " rst lane3"}, lane_out(3), 0);
    chk({nm, " rst beats"}, int'(bus.o_beats), 0);
    chk({nm, " rst ovf"}, int'(bus.o_overflow), 0);
    chk({nm, " rst perr"}, int'(bus.o_proto_err), 0);
    @(posedge clock); #1;
    resetn = 1;
  endtask
  function automatic int rnd();
    case ($urandom % 4)
      0: return 2047;
      1: return -2048;
      default: return int'($urandom_range(0, 4095)) - 2048;
    endcase
  endfunction
  initial begin
    resetn = 0; bus.i_ready = 1; bus.i_valid = 0; bus.i_first = 0; bus.i_last = 0; bus.i_dot_result = '0;
    repeat (2) @(posedge clock);
    #1;
    do_reset("init");
    drive(1, 1, 1, 5, -3, 0, 2047);
    chk("single valid", int'(bus.o_valid), 1);
    chk("single lane0", lane_out(0), 5);
    chk("single lane1", lane_out(1), -3);
    chk("single lane2", lane_out(2), 0);
    chk("single lane3", lane_out(3), 2047);
    chk("single beats", int'(bus.o_beats), 1);
    for (int i = 1; i <= 5; i++) begin
      drive(1, 1, 1, i * 10, -i, i, -2048);
      chk("b2b valid", int'(bus.o_valid), 1);
      chk("b2b lane0", lane_out(0), i * 10);
      chk("b2b lane1", lane_out(1), -i);
      chk("b2b lane3", lane_out(3), -2048);
    end
    idle(1);
    chk("drained valid", int'(bus.o_valid), 0);
    for (int g = 0; g < 2; g++) begin
      drive1(1, 1, 0, 100); idle(g * 2);
      drive1(1, 0, 0, 200); idle(g);
      drive1(1, 0, 0, -50);
      chk("burst4 not yet", int'(bus.o_valid), 0);
      drive1(1, 0, 1, 7);
      chk("burst4 valid", int'(bus.o_valid), 1);
      chk("burst4 lane0", lane_out(0), 257);
      chk("burst4 lane3", lane_out(3), 257);
      chk("burst4 beats", int'(bus.o_beats), 4);
      idle(1);
    end
    bus.i_ready = 0;
    drive1(1, 1, 1, 10);
    chk("bp first", lane_out(0), 10);
    drive1(1, 1, 1, 20);
    chk("bp held", lane_out(2), 10);
    chk("bp overflow", int'(bus.o_overflow), 1);
    chk("bp still valid", int'(bus.o_valid), 1);
    bus.i_ready = 1;
    idle(1);
    chk("bp drained", int'(bus.o_valid), 0);
    do_reset("proto");
    drive1(1, 0, 0, 55);
    chk("idle nonfirst perr", int'(bus.o_proto_err), 1);
    chk("idle nonfirst valid", int'(bus.o_valid), 0);
    drive1(1, 1, 0, 100);
    drive1(1, 1, 0, 3);
    drive1(1, 0, 1, 4);
    chk("restart lane1", lane_out(1), 7);
    chk("restart beats", int'(bus.o_beats), 2);
    idle(1);
    do_reset("maxburst");
    drive1(1, 1, 0, 1);
    repeat (3) drive1(1, 0, 0, 1);
    chk("max valid", int'(bus.o_valid), 1);
    chk("max beats", int'(bus.o_beats), 4);
    chk("max lane0", lane_out(0), 4);
    chk("max perr", int'(bus.o_proto_err), 1);
    idle(1);
    do_reset("wrap");
    drive1(1, 1, 0, 2047);
    drive1(1, 0, 0, 2047);
    drive1(1, 0, 1, 2047);
`ifdef PE_DOT_ACCUM_SAT_EN
    chk("sat lane0", lane_out(0), 4095);
    chk("sat flag", int'(bus.o_sat), 1);
`else
    chk("wrap lane0", lane_out(0), -2051);
`endif
    idle(1);
    bus.i_ready = 0;
    drive1(1, 1, 1, 33);
    drive1(1, 1, 0, 50);
    drive1(1, 0, 0, 50);
    do_reset("midburst");
    bus.i_ready = 1;
    drive1(1, 1, 1, 9);
    chk("post-reset lane0", lane_out(0), 9);
    chk("post-reset beats", int'(bus.o_beats), 1);
    idle(1);
    do_reset("random");
    for (int c = 0; c < 3000; c++) begin
      bus.i_ready = ($urandom % 4) != 0;
      drive(($urandom % 4) != 0, in_burst ? (($urandom % 10) == 0) : (($urandom % 6) != 0),
            ($urandom % 3) == 0, rnd(), rnd(), rnd(), rnd());
    end
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end
endmodule
